axi_burst_checker: RTL and testbench
====================================

// Module: axi_burst_checker
// PURPOSE
//  Passive AXI protocol checker/transaction counter, attached alongside axi_if on a single port.
//  Tracks up to OUTST outstanding bursts per direction, checks beat count against AxLEN and xLAST, checks ordering.
//  Counts completed transactions and reports sticky error flags.
//  Never drives the bus.
// PARAMETERS
//  LEN_W   8   AxLEN width (4 = AXI3, 8 = AXI4)
//  OUTST   4   max outstanding bursts per direction; depth of each length FIFO (>=1)
//  CNT_W   32  transaction counter width
// PORTS
//  ACLK        in   1              clock, all logic on rising edge
//  ARESET      in   1              synchronous active-high reset
//  AWLEN       in   LEN_W          write burst length-1
//  AWBURST     in   2              write burst type
//  AWVALID     in   1              write addr valid
//  AWREADY     in   1              write addr ready
//  WVALID      in   1              write data valid
//  WREADY      in   1              write data ready
//  WLAST       in   1              last write beat
//  BVALID      in   1              write resp valid
//  BREADY      in   1              write resp ready
//  ARLEN       in   LEN_W          read burst length-1
//  ARBURST     in   2              read burst type
//  ARVALID     in   1              read addr valid
//  ARREADY     in   1              read addr ready
//  RVALID      in   1              read data valid
//  RREADY      in   1              read data ready
//  RLAST       in   1              last read beat
//  err_clr     in   1              1-cycle pulse: clear err_flags/err_first
//  wr_txn_cnt  out  CNT_W          completed writes (B handshakes accepted)
//  rd_txn_cnt  out  CNT_W          completed reads (last R beats)
//  wr_outst    out  $clog2(OUTST+1) writes: AW accepted, B not yet seen
//  rd_outst    out  $clog2(OUTST+1) reads: AR accepted, last R not yet seen
//  err_flags   out  8              sticky: [0]AW_OVF [1]W_NO_AW [2]WLAST [3]B_EARLY [4]AR_OVF [5]R_NO_AR [6]RLAST [7]RSVD_BURST
//  err_first   out  3              index of first error; valid while err_flags!=0
// BEHAVIOUR
//  - Handshake = xVALID & xREADY, sampled at the ACLK edge. All outputs are registered and update 1 cycle after the event.
//  - Reset: all outputs 0, both FIFOs emptied, beat counters 0, b_pend 0. Reset mid-burst discards all in-flight state.
//  - Write side: AW handshake pushes AWLEN into the AW FIFO. The W beat counter counts against the FIFO head.
//      - A beat where counter==head ends the burst: pop, counter->0, b_pend++. Otherwise counter++.
//      - B handshake with b_pend>0: b_pend--, wr_txn_cnt++. With b_pend==0: set B_EARLY, no count.
//      - wr_outst = fifo_count + b_pend. AW handshake when wr_outst==OUTST: set AW_OVF, AW dropped.
//      - W beat while FIFO empty: set W_NO_AW, beat ignored. W-before-AW is unsupported by decision.
//      - WLAST != (counter==head) on any beat: set WLAST. Burst boundary still follows AWLEN.
//  - Read side: same rules on AR FIFO/R beats.
//      - Last expected beat pops the FIFO and increments rd_txn_cnt.
//      - rd_outst = fifo_count. Overflow sets AR_OVF, empty sets R_NO_AR, mismatch sets RLAST.
//  - AWBURST or ARBURST == 2'b11 at handshake: set RSVD_BURST. The transaction is still tracked.
//  - Simultaneous events in one cycle:
//      - Push+pop on a FIFO is legal, including when full.
//      - Overflow is judged on pre-cycle occupancy minus same-cycle completion, so a push with a same-cycle pop/B is accepted.
//      - Write and read sides are fully independent.
//  - Counters saturate at all-ones. No wrap.
//  - err_flags are sticky. err_clr clears them, but a same-cycle new error wins and is set.
//      - err_first loads when err_flags==0 and >=1 error fires: lowest index among that cycle's errors. Held until cleared.
// TESTING
//  - AWLEN=3, 4 W beats with WLAST on beat 4, then B -> wr_txn_cnt=1, wr_outst 1->1->0, err_flags=0.
//  - OUTST=4: 5 ARs with ARLEN=0, no R -> rd_outst=4, err_flags=8'h10, err_first=4.
//    Then 4 R beats with RLAST=1 -> rd_txn_cnt=4.
//  - AWLEN=1, WLAST on beat 1 -> err_flags[2]=1, err_first=2. Beat 2 still closes the burst; b_pend=1.
//  - B handshake with nothing outstanding, same cycle as W beat with empty FIFO -> err_flags=8'h0A, err_first=1.
//  - 4 outstanding writes, 5th AW in same cycle as a B -> no AW_OVF, wr_outst stays 4.
//    Then ARESET mid-burst -> all outputs 0.
//  - CNT_W=4: 17 single-beat reads -> rd_txn_cnt saturates at 15.
//    err_clr with no concurrent error -> err_flags=0.

Source files
------------

// File: rtl/axi_burst_checker.sv
// Passive AXI burst checker: tracks outstanding bursts per direction, checks beat
// counts against AxLEN and xLAST, counts completed transactions, reports sticky errors.

module axi_burst_checker_side #(
    parameter int LEN_W    = 8,
    parameter int OUTST    = 4,
    parameter int CNT_W    = 32,
    parameter int OW       = 3,
    parameter bit HAS_RESP = 1'b1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             a_hs,
    input  logic [LEN_W-1:0] a_len,
    input  logic             d_hs,
    input  logic             d_last,
    input  logic             resp_hs,
    output logic [CNT_W-1:0] txn_cnt,
    output logic [OW-1:0]    outst,
    output logic             ovf_err,
    output logic             no_a_err,
    output logic             last_err,
    output logic             early_err
);
    localparam int PW = (OUTST > 1) ? $clog2(OUTST) : 1;

    logic [LEN_W-1:0] len_mem [OUTST];
    logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [OW-1:0]    count_reg, count_next;
    logic [OW-1:0]    pend_reg, pend_next;
    logic [OW-1:0]    outst_reg;
    logic [LEN_W-1:0] beat_reg;
    logic [CNT_W-1:0] txn_reg;
    logic [LEN_W-1:0] head;
    logic             empty, beat, at_end, pop, resp_ok, done, push;

    always_comb begin
        head       = len_mem[rd_ptr_reg];
        empty      = (count_reg == '0);
        beat       = d_hs && !empty;
        at_end     = (beat_reg == head);
        pop        = beat && at_end;
        resp_ok    = HAS_RESP && resp_hs && (pend_reg != '0);
        done       = HAS_RESP ? resp_ok : pop;
        // A same-cycle completion frees a slot for this cycle's push.
        push       = a_hs && ((int'(outst_reg) - int'(done)) < OUTST);
        count_next = count_reg + OW'(push) - OW'(pop);
        pend_next  = HAS_RESP ? (pend_reg + OW'(pop) - OW'(resp_ok)) : '0;
        ovf_err    = a_hs && !push;
        no_a_err   = d_hs && empty;
        last_err   = beat && (d_last != at_end);
        early_err  = HAS_RESP && resp_hs && (pend_reg == '0);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            len_mem[wr_ptr_reg] <= a_len;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            pend_reg   <= '0;
            outst_reg  <= '0;
            beat_reg   <= '0;
            txn_reg    <= '0;
        end else begin
            count_reg <= count_next;
            pend_reg  <= pend_next;
            outst_reg <= count_next + pend_next;
            if (push) begin
                wr_ptr_reg <= (wr_ptr_reg == PW'(OUTST - 1)) ? '0 : wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= (rd_ptr_reg == PW'(OUTST - 1)) ? '0 : rd_ptr_reg + PW'(1);
            end
            if (beat) begin
                beat_reg <= pop ? '0 : beat_reg + LEN_W'(1);
            end
            if (done && (txn_reg != '1)) begin
                txn_reg <= txn_reg + CNT_W'(1);
            end
        end
    end

    assign txn_cnt = txn_reg;
    assign outst   = outst_reg;
endmodule

module axi_burst_checker #(
    parameter int LEN_W = 8,
    parameter int OUTST = 4,
    parameter int CNT_W = 32
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    input  logic [LEN_W-1:0]           AWLEN,
    input  logic [1:0]                 AWBURST,
    input  logic                       AWVALID,
    input  logic                       AWREADY,
    input  logic                       WVALID,
    input  logic                       WREADY,
    input  logic                       WLAST,
    input  logic                       BVALID,
    input  logic                       BREADY,
    input  logic [LEN_W-1:0]           ARLEN,
    input  logic [1:0]                 ARBURST,
    input  logic                       ARVALID,
    input  logic                       ARREADY,
    input  logic                       RVALID,
    input  logic                       RREADY,
    input  logic                       RLAST,
    input  logic                       err_clr,
    output logic [CNT_W-1:0]           wr_txn_cnt,
    output logic [CNT_W-1:0]           rd_txn_cnt,
    output logic [$clog2(OUTST+1)-1:0] wr_outst,
    output logic [$clog2(OUTST+1)-1:0] rd_outst,
    output logic [7:0]                 err_flags,
    output logic [2:0]                 err_first
);
    localparam int OW = $clog2(OUTST + 1);

    logic [1:0]       a_hs_v, d_hs_v, d_last_v, resp_v;
    logic [1:0]       ovf_v, no_a_v, last_v, early_v;
    logic [LEN_W-1:0] a_len_v [2];
    logic [CNT_W-1:0] txn_v [2];
    logic [OW-1:0]    outst_v [2];
    logic             rsvd;
    logic [7:0]       err_vec, flags_next;
    logic [2:0]       first_idx;
    logic [7:0]       err_flags_reg;
    logic [2:0]       err_first_reg;

    // Index 0 is the write side, index 1 the read side.
    assign a_hs_v     = {ARVALID & ARREADY, AWVALID & AWREADY};
    assign d_hs_v     = {RVALID & RREADY, WVALID & WREADY};
    assign d_last_v   = {RLAST, WLAST};
    assign resp_v     = {1'b0, BVALID & BREADY};
    assign a_len_v[0] = AWLEN;
    assign a_len_v[1] = ARLEN;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_side
            axi_burst_checker_side #(
                .LEN_W   (LEN_W),
                .OUTST   (OUTST),
                .CNT_W   (CNT_W),
                .OW      (OW),
                .HAS_RESP(gi == 0)
            ) u_side (
                .clk      (ACLK),
                .srst     (ARESET),
                .a_hs     (a_hs_v[gi]),
                .a_len    (a_len_v[gi]),
                .d_hs     (d_hs_v[gi]),
                .d_last   (d_last_v[gi]),
                .resp_hs  (resp_v[gi]),
                .txn_cnt  (txn_v[gi]),
                .outst    (outst_v[gi]),
                .ovf_err  (ovf_v[gi]),
                .no_a_err (no_a_v[gi]),
                .last_err (last_v[gi]),
                .early_err(early_v[gi])
            );
        end
    endgenerate

    always_comb begin
        rsvd = (a_hs_v[0] && (AWBURST == 2'b11)) || (a_hs_v[1] && (ARBURST == 2'b11));
        err_vec = {rsvd, last_v[1], no_a_v[1], ovf_v[1],
                   early_v[0] | early_v[1], last_v[0], no_a_v[0], ovf_v[0]};
        first_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (err_vec[i]) first_idx = 3'(i);
        end
        flags_next = (err_clr ? 8'h00 : err_flags_reg) | err_vec;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            err_flags_reg <= '0;
            err_first_reg <= '0;
        end else begin
            err_flags_reg <= flags_next;
            if ((err_flags_reg == '0 || err_clr) && err_vec != '0) begin
                err_first_reg <= first_idx;
            end else if (err_clr) begin
                err_first_reg <= '0;
            end
        end
    end

    assign wr_txn_cnt = txn_v[0];
    assign rd_txn_cnt = txn_v[1];
    assign wr_outst   = outst_v[0];
    assign rd_outst   = outst_v[1];
    assign err_flags  = err_flags_reg;
    assign err_first  = err_first_reg;
endmodule

// File: tb/tb_axi_burst_checker.sv
// Bench for axi_burst_checker: directed scenarios plus random traffic checked
// against a queue-based transaction model.

module tb_axi_burst_checker;
    localparam int LEN_W = 8;
    localparam int OUTST = 4;
    localparam int CNT_W = 4;
    localparam int OW    = $clog2(OUTST + 1);
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             ACLK = 1'b0;
    logic             ARESET;
    logic [LEN_W-1:0] AWLEN, ARLEN;
    logic [1:0]       AWBURST, ARBURST;
    logic             AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
    logic             ARVALID, ARREADY, RVALID, RREADY, RLAST, err_clr;
    logic [CNT_W-1:0] wr_txn_cnt, rd_txn_cnt;
    logic [OW-1:0]    wr_outst, rd_outst;
    logic [7:0]       err_flags;
    logic [2:0]       err_first;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state
    int         aw_q[$];
    int         ar_q[$];
    int         w_beats, r_beats, b_pend, m_wr_cnt, m_rd_cnt;
    logic [7:0] m_flags;
    logic [2:0] m_first;

    axi_burst_checker #(.LEN_W(LEN_W), .OUTST(OUTST), .CNT_W(CNT_W)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWLEN(AWLEN), .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST),
        .BVALID(BVALID), .BREADY(BREADY),
        .ARLEN(ARLEN), .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST),
        .err_clr(err_clr),
        .wr_txn_cnt(wr_txn_cnt), .rd_txn_cnt(rd_txn_cnt),
        .wr_outst(wr_outst), .rd_outst(rd_outst),
        .err_flags(err_flags), .err_first(err_first)
    );

    always #5 ACLK = ~ACLK;

    function automatic void model_eval();
        logic [7:0] e;
        bit         wr_done, rd_done, lastb;
        if (ARESET) begin
            aw_q.delete(); ar_q.delete();
            w_beats = 0; r_beats = 0; b_pend = 0;
            m_wr_cnt = 0; m_rd_cnt = 0; m_flags = 0; m_first = 0;
            return;
        end
        e = 8'h00;
        wr_done = BVALID && BREADY && (b_pend > 0);
        rd_done = RVALID && RREADY && (ar_q.size() > 0) && (r_beats == ar_q[0]);
        if (AWVALID && AWREADY) begin
            if (AWBURST == 2'b11) e[7] = 1'b1;
            if (aw_q.size() + b_pend - int'(wr_done) >= OUTST) e[0] = 1'b1;
        end
        if (ARVALID && ARREADY) begin
            if (ARBURST == 2'b11) e[7] = 1'b1;
            if (ar_q.size() - int'(rd_done) >= OUTST) e[4] = 1'b1;
        end
        if (BVALID && BREADY) begin
            if (b_pend == 0) e[3] = 1'b1;
            else begin
                b_pend--;
                if (m_wr_cnt < CMAX) m_wr_cnt++;
            end
        end
        if (WVALID && WREADY) begin
            if (aw_q.size() == 0) e[1] = 1'b1;
            else begin
                lastb = (w_beats == aw_q[0]);
                if (WLAST != lastb) e[2] = 1'b1;
                if (lastb) begin
                    void'(aw_q.pop_front()); w_beats = 0; b_pend++;
                end else w_beats++;
            end
        end
        if (RVALID && RREADY) begin
            if (ar_q.size() == 0) e[5] = 1'b1;
            else begin
                lastb = (r_beats == ar_q[0]);
                if (RLAST != lastb) e[6] = 1'b1;
                if (lastb) begin
                    void'(ar_q.pop_front()); r_beats = 0;
                    if (m_rd_cnt < CMAX) m_rd_cnt++;
                end else r_beats++;
            end
        end
        if (AWVALID && AWREADY && !e[0]) aw_q.push_back(int'(AWLEN));
        if (ARVALID && ARREADY && !e[4]) ar_q.push_back(int'(ARLEN));
        if (m_flags == 0 || err_clr) begin
            if (e != 0) begin
                for (int i = 7; i >= 0; i--) if (e[i]) m_first = 3'(i);
            end else if (err_clr) m_first = 3'd0;
        end
        m_flags = (err_clr ? 8'h00 : m_flags) | e;
    endfunction

    task automatic idle();
        ARESET = 0; err_clr = 0;
        AWVALID = 0; AWREADY = 0; AWLEN = 0; AWBURST = 2'b01;
        WVALID = 0; WREADY = 0; WLAST = 0; BVALID = 0; BREADY = 0;
        ARVALID = 0; ARREADY = 0; ARLEN = 0; ARBURST = 2'b01;
        RVALID = 0; RREADY = 0; RLAST = 0;
    endtask

    task automatic tick();
        model_eval();
        @(posedge ACLK);
        #1;
        idle();
    endtask

    task automatic do_reset();
        ARESET = 1; tick();
    endtask

    task automatic test_reset();
        ARESET = 1; tick();
        ARESET = 1; tick();
        n_checks++; if (wr_txn_cnt !== 0) begin n_err++; $display("FAIL reset_wr_cnt got=%0d exp=0", wr_txn_cnt); end
        n_checks++; if (rd_txn_cnt !== 0) begin n_err++; $display("FAIL reset_rd_cnt got=%0d exp=0", rd_txn_cnt); end
        n_checks++; if (wr_outst !== 0 || rd_outst !== 0) begin n_err++; $display("FAIL reset_outst got=%0d/%0d exp=0/0", wr_outst, rd_outst); end
        n_checks++; if (err_flags !== 0 || err_first !== 0) begin n_err++; $display("FAIL reset_err got=%h/%0d exp=00/0", err_flags, err_first); end
        $display("test_reset done");
    endtask

    task automatic test_write_burst();
        do_reset();
        AWVALID = 1; AWREADY = 1; AWLEN = 3; tick();
        n_checks++; if (wr_outst !== 1) begin n_err++; $display("FAIL wb_outst_aw got=%0d exp=1", wr_outst); end
        for (int i = 0; i < 4; i++) begin
            WVALID = 1; WREADY = 1; WLAST = (i == 3); tick();
        end
        n_checks++; if (wr_outst !== 1 || wr_txn_cnt !== 0) begin n_err++; $display("FAIL wb_after_w got=%0d/%0d exp=1/0", wr_outst, wr_txn_cnt); end
        BVALID = 1; BREADY = 1; tick();
        n_checks++; if (wr_txn_cnt !== 1) begin n_err++; $display("FAIL wb_cnt got=%0d exp=1", wr_txn_cnt); end
        n_checks++; if (wr_outst !== 0 || err_flags !== 0) begin n_err++; $display("FAIL wb_final got=%0d/%h exp=0/00", wr_outst, err_flags); end
        $display("test_write_burst txn wr=%0d", wr_txn_cnt);
    endtask

    task automatic test_read_overflow();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            ARVALID = 1; ARREADY = 1; ARLEN = 0; tick();
        end
        n_checks++; if (rd_outst !== 4) begin n_err++; $display("FAIL ro_outst got=%0d exp=4", rd_outst); end
        n_checks++; if (err_flags !== 8'h10 || err_first !== 4) begin n_err++; $display("FAIL ro_err got=%h/%0d exp=10/4", err_flags, err_first); end
        for (int i = 0; i < 4; i++) begin
            RVALID = 1; RREADY = 1; RLAST = 1; tick();
        end
        n_checks++; if (rd_txn_cnt !== 4 || rd_outst !== 0) begin n_err++; $display("FAIL ro_drain got=%0d/%0d exp=4/0", rd_txn_cnt, rd_outst); end
        $display("test_read_overflow txn rd=%0d", rd_txn_cnt);
    endtask

    task automatic test_wlast_mismatch();
        do_reset();
        AWVALID = 1; AWREADY = 1; AWLEN = 1; tick();
        WVALID = 1; WREADY = 1; WLAST = 1; tick();
        n_checks++; if (err_flags !== 8'h04 || err_first !== 2) begin n_err++; $display("FAIL wl_err got=%h/%0d exp=04/2", err_flags, err_first); end
        WVALID = 1; WREADY = 1; WLAST = 1; tick();
        n_checks++; if (wr_outst !== 1 || err_flags !== 8'h04) begin n_err++; $display("FAIL wl_close got=%0d/%h exp=1/04", wr_outst, err_flags); end
        WVALID = 1; WREADY = 1; WLAST = 1; tick();
        n_checks++; if (err_flags !== 8'h06 || err_first !== 2) begin n_err++; $display("FAIL wl_extra got=%h/%0d exp=06/2", err_flags, err_first); end
        BVALID = 1; BREADY = 1; tick();
        n_checks++; if (wr_txn_cnt !== 1 || wr_outst !== 0) begin n_err++; $display("FAIL wl_b got=%0d/%0d exp=1/0", wr_txn_cnt, wr_outst); end
        $display("test_wlast_mismatch txn wr=%0d", wr_txn_cnt);
    endtask

    task automatic test_simultaneous_errors();
        do_reset();
        BVALID = 1; BREADY = 1; WVALID = 1; WREADY = 1; WLAST = 1; tick();
        n_checks++; if (err_flags !== 8'h0A || err_first !== 1) begin n_err++; $display("FAIL se_err got=%h/%0d exp=0a/1", err_flags, err_first); end
        n_checks++; if (wr_txn_cnt !== 0) begin n_err++; $display("FAIL se_cnt got=%0d exp=0", wr_txn_cnt); end
        $display("test_simultaneous_errors flags=%h", err_flags);
    endtask

    task automatic test_push_with_b();
        do_reset();
        AWVALID = 1; AWREADY = 1; AWLEN = 0; tick();
        WVALID = 1; WREADY = 1; WLAST = 1; tick();
        for (int i = 0; i < 3; i++) begin
            AWVALID = 1; AWREADY = 1; AWLEN = 0; tick();
        end
        n_checks++; if (wr_outst !== 4) begin n_err++; $display("FAIL pb_full got=%0d exp=4", wr_outst); end
        AWVALID = 1; AWREADY = 1; AWLEN = 0; BVALID = 1; BREADY = 1; tick();
        n_checks++; if (err_flags !== 0 || wr_outst !== 4 || wr_txn_cnt !== 1) begin n_err++; $display("FAIL pb_push got=%h/%0d/%0d exp=00/4/1", err_flags, wr_outst, wr_txn_cnt); end
        ARVALID = 1; ARREADY = 1; ARLEN = 7; tick();
        RVALID = 1; RREADY = 1; tick();
        ARESET = 1; tick();
        n_checks++; if (wr_txn_cnt !== 0 || rd_txn_cnt !== 0 || wr_outst !== 0 || rd_outst !== 0 || err_flags !== 0 || err_first !== 0) begin
            n_err++; $display("FAIL pb_reset got=%0d/%0d/%0d/%0d/%h/%0d exp=all 0", wr_txn_cnt, rd_txn_cnt, wr_outst, rd_outst, err_flags, err_first);
        end
        WVALID = 1; WREADY = 1; WLAST = 1; tick();
        n_checks++; if (err_flags !== 8'h02) begin n_err++; $display("FAIL pb_discard got=%h exp=02", err_flags); end
        $display("test_push_with_b txn wr_outst=%0d", wr_outst);
    endtask

    task automatic test_back_to_back();
        do_reset();
        ARVALID = 1; ARREADY = 1; tick();
        for (int i = 0; i < 16; i++) begin
            ARVALID = 1; ARREADY = 1; RVALID = 1; RREADY = 1; RLAST = 1; tick();
        end
        RVALID = 1; RREADY = 1; RLAST = 1; tick();
        n_checks++; if (rd_txn_cnt !== 15 || err_flags !== 0) begin n_err++; $display("FAIL bb_sat got=%0d/%h exp=15/00", rd_txn_cnt, err_flags); end
        RVALID = 1; RREADY = 1; tick();
        n_checks++; if (err_flags !== 8'h20 || err_first !== 5) begin n_err++; $display("FAIL bb_noar got=%h/%0d exp=20/5", err_flags, err_first); end
        err_clr = 1; tick();
        n_checks++; if (err_flags !== 0) begin n_err++; $display("FAIL bb_clr got=%h exp=00", err_flags); end
        RVALID = 1; RREADY = 1; tick();
        err_clr = 1; AWVALID = 1; AWREADY = 1; AWBURST = 2'b11; tick();
        n_checks++; if (err_flags !== 8'h80 || err_first !== 7 || wr_outst !== 1) begin n_err++; $display("FAIL bb_clr_new got=%h/%0d/%0d exp=80/7/1", err_flags, err_first, wr_outst); end
        $display("test_back_to_back txn rd=%0d", rd_txn_cnt);
    endtask

    task automatic test_random();
        bit good;
        do_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            ARESET  = ($urandom_range(0, 299) == 0);
            err_clr = ($urandom_range(0, 39) == 0);
            AWVALID = ($urandom_range(0, 3) == 0); AWREADY = ($urandom_range(0, 3) != 0);
            AWLEN   = LEN_W'($urandom_range(0, 3));
            AWBURST = ($urandom_range(0, 19) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            WVALID  = ($urandom_range(0, 1) == 0); WREADY = ($urandom_range(0, 3) != 0);
            good    = (aw_q.size() > 0) && (w_beats == aw_q[0]);
            WLAST   = ($urandom_range(0, 19) == 0) ? !good : good;
            BVALID  = ($urandom_range(0, 2) == 0); BREADY = ($urandom_range(0, 3) != 0);
            ARVALID = ($urandom_range(0, 3) == 0); ARREADY = ($urandom_range(0, 3) != 0);
            ARLEN   = LEN_W'($urandom_range(0, 3));
            ARBURST = ($urandom_range(0, 19) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            RVALID  = ($urandom_range(0, 1) == 0); RREADY = ($urandom_range(0, 3) != 0);
            good    = (ar_q.size() > 0) && (r_beats == ar_q[0]);
            RLAST   = ($urandom_range(0, 19) == 0) ? !good : good;
            tick();
            n_checks++; if (wr_txn_cnt !== CNT_W'(m_wr_cnt)) begin n_err++; $display("FAIL rnd_wr_cnt cyc=%0d got=%0d exp=%0d", cyc, wr_txn_cnt, m_wr_cnt); end
            n_checks++; if (rd_txn_cnt !== CNT_W'(m_rd_cnt)) begin n_err++; $display("FAIL rnd_rd_cnt cyc=%0d got=%0d exp=%0d", cyc, rd_txn_cnt, m_rd_cnt); end
            n_checks++; if (wr_outst !== OW'(aw_q.size() + b_pend)) begin n_err++; $display("FAIL rnd_wr_outst cyc=%0d got=%0d exp=%0d", cyc, wr_outst, aw_q.size() + b_pend); end
            n_checks++; if (rd_outst !== OW'(ar_q.size())) begin n_err++; $display("FAIL rnd_rd_outst cyc=%0d got=%0d exp=%0d", cyc, rd_outst, ar_q.size()); end
            n_checks++; if (err_flags !== m_flags) begin n_err++; $display("FAIL rnd_flags cyc=%0d got=%h exp=%h", cyc, err_flags, m_flags); end
            if (m_flags != 0) begin
                n_checks++; if (err_first !== m_first) begin n_err++; $display("FAIL rnd_first cyc=%0d got=%0d exp=%0d", cyc, err_first, m_first); end
            end
        end
        $display("test_random txn wr=%0d rd=%0d flags=%h", m_wr_cnt, m_rd_cnt, m_flags);
    endtask

    initial begin
        idle();
        test_reset();
        test_write_burst();
        test_read_overflow();
        test_wlast_mismatch();
        test_simultaneous_errors();
        test_push_with_b();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
